mux4_rr_arbiter: RTL and testbench

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

---
 rtl/mux4_rr_arbiter_if.sv | 31 +++
 rtl/mux4_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Handshake/data bundle between four requesters and the round-robin mux arbiter.
// The master side drives requests and lane data; the slave side (the arbiter)
// returns grant, select, valid and the muxed data.
interface mux4_rr_arbiter_if #(
    parameter int unsigned W = 1
);
    logic [3:0]     req;
    logic [4*W-1:0] data_in;
    logic [3:0]     grant;
    logic [1:0]     sel;
    logic           valid;
    logic [W-1:0]   data_out;

    modport master (
        output req,
        output data_in,
        input  grant,
        input  sel,
        input  valid,
        input  data_out
    );

    modport slave (
        input  req,
        input  data_in,
        output grant,
        output sel,
        output valid,
        output data_out
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time, driving a shared W-bit mux.
// Grant, select and valid are registered; data_out is a combinational mux of the
// selected lane. The interface instance must be built with the same W.
module mux4_rr_arbiter #(
    parameter int unsigned W        = 1,
    parameter int unsigned MAX_HOLD = 4
) (
    input logic              clk,
    input logic              rst_n,
    mux4_rr_arbiter_if.slave bus
);
    localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e     state_q;
    logic [3:0] grant_q;
    logic [1:0] sel_q;
    logic       valid_q;
    logic [1:0] last_q;
    logic [3:0] hold_q;

    // First set bit of r searching upward from last+1 with wrap; last itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] pick;
        logic       found;
        logic [1:0] idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    logic [3:0] req_others;
    logic [1:0] win_any;
    logic [1:0] win_oth;

    // Winner candidates: any requester, and any requester other than the current owner.
    always_comb begin
        req_others = bus.req & ~(4'b0001 << sel_q);
        win_any    = rr_pick(bus.req, last_q);
        win_oth    = rr_pick(req_others, last_q);
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            last_q  <= 2'd3;
            hold_q  <= 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req != 4'b0000) begin
                        state_q <= StOwn;
                        grant_q <= 4'b0001 << win_any;
                        sel_q   <= win_any;
                        last_q  <= win_any;
                        valid_q <= 1'b1;
                        hold_q  <= 4'd1;
                    end
                end
                StOwn: begin
                    if (!bus.req[sel_q]) begin
                        // Owner released: hand over in the same edge, or fall idle.
                        if (bus.req != 4'b0000) begin
                            grant_q <= 4'b0001 << win_any;
                            sel_q   <= win_any;
                            last_q  <= win_any;
                            hold_q  <= 4'd1;
                        end else begin
                            state_q <= StIdle;
                            grant_q <= 4'b0000;
                            valid_q <= 1'b0;
                            hold_q  <= 4'd0;
                        end
                    end else if (hold_q < MaxHold) begin
                        hold_q <= hold_q + 4'd1;
                    end else if (req_others != 4'b0000) begin
                        // Hold budget spent and someone else waits: force rotation.
                        grant_q <= 4'b0001 << win_oth;
                        sel_q   <= win_oth;
                        last_q  <= win_oth;
                        hold_q  <= 4'd1;
                    end
                    // Otherwise keep the grant; hold_q stays saturated.
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= 4'b0000;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    logic [W-1:0] data_mux;

    // Shared output mux; forced to zero when nobody owns it or reset is asserted.
    always_comb begin
        data_mux = '0;
        if (valid_q && rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_q == 2'(i)) begin
                    data_mux = bus.data_in[i*W +: W];
                end
            end
        end
    end

    assign bus.grant    = grant_q;
    assign bus.sel      = sel_q;
    assign bus.valid    = valid_q;
    assign bus.data_out = data_mux;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a behavioural round-robin model.
module tb_mux4_rr_arbiter;
    localparam int W        = 4;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mux4_rr_arbiter_if #(.W(W)) bus ();

    mux4_rr_arbiter #(
        .W        (W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state.
    bit m_own;
    int m_sel;
    int m_last;
    int m_hold;

    function automatic int search(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [3:0] r, input logic rn);
        int w;
        if (!rn) begin
            m_own = 0; m_sel = 0; m_last = 3; m_hold = 0;
        end else if (!m_own || !r[m_sel]) begin
            w = search(r, m_last);
            if (w >= 0) begin
                m_own = 1; m_sel = w; m_last = w; m_hold = 1;
            end else begin
                m_own = 0;
            end
        end else if (m_hold < MAX_HOLD) begin
            m_hold++;
        end else begin
            w = search(r & ~(4'b0001 << m_sel), m_last);
            if (w >= 0) begin
                m_sel = w; m_last = w; m_hold = 1;
            end
        end
    endtask

    // One clock: drive inputs, check the combinational mux, step DUT and model, compare.
    task automatic cycle(input logic [3:0] r, input logic [15:0] d, input logic rn);
        logic [3:0] exp_data;
        bus.req     = r;
        bus.data_in = d;
        rst_n       = rn;
        #1;
        exp_data = (m_own && rn) ? d[m_sel*4 +: 4] : 4'h0;
        check("data_out_pre", 32'(bus.data_out), 32'(exp_data));
        @(posedge clk);
        model_edge(r, rn);
        #1;
        check("grant", 32'(bus.grant), m_own ? 32'(4'b0001 << m_sel) : 32'd0);
        check("sel", 32'(bus.sel), 32'(m_sel));
        check("valid", 32'(bus.valid), 32'(m_own));
        check("onehot", 32'($onehot0(bus.grant)), 32'd1);
        check("valid_or", 32'(bus.valid), 32'(|bus.grant));
        if (bus.valid) check("req_at_grant", 32'(r[bus.sel]), 32'd1);
    endtask

    initial begin
        logic [3:0] rr;
        checks   = 0;
        failures = 0;
        m_own = 0; m_sel = 0; m_last = 3; m_hold = 0;
        bus.req     = 4'b0000;
        bus.data_in = '0;
        rst_n       = 1'b0;

        // Reset dominates requests.
        cycle(4'b1111, 16'h1234, 1'b0);
        cycle(4'b1111, 16'h1234, 1'b0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_data", 32'(bus.data_out), 32'd0);

        // All requesting: four grants each, rotating, then back to 0.
        for (int i = 0; i < 17; i++) begin
            cycle(4'b1111, 16'h0000, 1'b1);
            check("rot_grant", 32'(bus.grant), 32'(4'b0001 << ((i / 4) % 4)));
            check("rot_valid", 32'(bus.valid), 32'd1);
        end

        // Single requester saturates, then releases to idle with sel kept.
        cycle(4'b0000, 16'h0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0100, 16'h0000, 1'b1);
            check("single_grant", 32'(bus.grant), 32'h4);
            check("single_sel", 32'(bus.sel), 32'd2);
        end
        cycle(4'b0000, 16'h0000, 1'b1);
        check("idle_grant", 32'(bus.grant), 32'd0);
        check("idle_valid", 32'(bus.valid), 32'd0);
        check("idle_sel", 32'(bus.sel), 32'd2);

        // Early release hands over without a bubble.
        cycle(4'b0000, 16'h0000, 1'b0);
        cycle(4'b0011, 16'h0000, 1'b1);
        check("early_own0", 32'(bus.grant), 32'h1);
        cycle(4'b0011, 16'h0000, 1'b1);
        cycle(4'b0010, 16'h0000, 1'b1);
        check("early_grant", 32'(bus.grant), 32'h2);
        check("early_valid", 32'(bus.valid), 32'd1);

        // Data path: lane 1 of A5C3 is C; zero when idle.
        cycle(4'b0000, 16'hA5C3, 1'b0);
        cycle(4'b0010, 16'hA5C3, 1'b1);
        check("data_lane1", 32'(bus.data_out), 32'hC);
        cycle(4'b0000, 16'hA5C3, 1'b1);
        check("data_idle", 32'(bus.data_out), 32'h0);

        // Reset mid-ownership, then requester 0 wins.
        cycle(4'b0000, 16'h0000, 1'b0);
        cycle(4'b0100, 16'h0000, 1'b1);
        cycle(4'b0101, 16'h0000, 1'b1);
        check("mid_own2", 32'(bus.grant), 32'h4);
        cycle(4'b0101, 16'h0000, 1'b0);
        check("mid_rst_grant", 32'(bus.grant), 32'd0);
        check("mid_rst_sel", 32'(bus.sel), 32'd0);
        cycle(4'b0101, 16'h0000, 1'b1);
        check("mid_regrant", 32'(bus.grant), 32'h1);

        // Random traffic with sticky requests and rare resets.
        rr = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
            cycle(rr, 16'($urandom), ($urandom_range(0, 39) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
